// File: rtl/alu_op_sequencer.sv
// Purpose: issues one ALU operation at a time, waits its settle time, and returns the captured result.
// Latency: the response is valid N cycles after accept (N per op class), or 1 cycle after accept for an error.
// Backpressure: holds the response until rsp_ready; req_ready is low outside IDLE and requests there are dropped.
module alu_op_sequencer #(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [7:0]  alu_ctrl,
    output logic [4:0]  alu_shamt,
    input  logic [63:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_zero,
    output logic        busy
);

    localparam logic [7:0] OP_MUL = 8'h06;
    localparam logic [7:0] OP_DIV = 8'h07;

    localparam int MD_MAX  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MAX_CYC = (MD_MAX > SIMPLE_CYCLES) ? MD_MAX : SIMPLE_CYCLES;
    // The counter only ever holds N-1, so log2(max N) bits are enough.
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t         state_q,      state_d;
    logic [CW-1:0]  cnt_q,        cnt_d;
    logic           err_pend_q,   err_pend_d;
    logic [31:0]    alu_a_q,      alu_a_d;
    logic [31:0]    alu_b_q,      alu_b_d;
    logic [7:0]     alu_ctrl_q,   alu_ctrl_d;
    logic [4:0]     alu_shamt_q,  alu_shamt_d;
    logic [63:0]    rsp_result_q, rsp_result_d;
    logic           rsp_err_q,    rsp_err_d;

    logic           op_legal;
    logic           op_ok;

    // Opcodes 0x02..0x0E are implemented by the ALU; a zero divisor is rejected up front.
    assign op_legal = (req_op >= 8'h02) && (req_op <= 8'h0E);
    assign op_ok    = op_legal && !((req_op == OP_DIV) && (req_b == 32'd0));

    // Next-state logic: accept in IDLE, count down the settle time in EXEC, hold until handshake in RESP.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_pend_d   = err_pend_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_shamt_d  = alu_shamt_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    alu_ctrl_d  = req_op;
                    alu_shamt_d = req_shamt;
                    state_d     = ST_EXEC;
                    // Rejected ops still spend one cycle in EXEC so the error
                    // response shows up one cycle after accept, like a simple op.
                    err_pend_d  = !op_ok;
                    if (!op_ok)
                        cnt_d = '0;
                    else if (req_op == OP_MUL)
                        cnt_d = CW'(MUL_CYCLES - 1);
                    else if (req_op == OP_DIV)
                        cnt_d = CW'(DIV_CYCLES - 1);
                    else
                        cnt_d = CW'(SIMPLE_CYCLES - 1);
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    // A rejected op never looks at the ALU output.
                    rsp_result_d = err_pend_q ? 64'd0 : alu_result;
                    rsp_err_d    = err_pend_q;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            err_pend_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            alu_shamt_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_pend_q   <= err_pend_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_shamt_q  <= alu_shamt_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_zero   = (rsp_result_q == 64'd0);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign alu_shamt  = alu_shamt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: randomized and directed checks of alu_op_sequencer against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: the response side is stalled explicitly in one scenario.
module tb_alu_op_sequencer;

    logic        clk;
    logic        clr_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [7:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_err;
    logic        rsp_zero;
    logic        busy;

    int asserts = 0;
    int fails   = 0;

    alu_op_sequencer dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: what the ALU computes for a given opcode and operands.
    function automatic logic [63:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [31:0]        t;
        logic signed [63:0] p;
        t = 32'd0;
        case (op)
            8'h02: t = a & b;
            8'h03: t = a | b;
            8'h04: t = a + b;
            8'h05: t = a - b;
            8'h06: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            8'h07: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
            8'h08: t = 32'd0 - a;
            8'h09: t = ~a;
            8'h0A: t = (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
            8'h0B: t = (sh == 5'd0) ? a : ((a << sh) | (a >> (6'd32 - {1'b0, sh})));
            8'h0C: t = a << sh;
            8'h0D: t = a >> sh;
            8'h0E: t = $signed(a) >>> sh;
            default: t = 32'd0;
        endcase
        return {32'd0, t};
    endfunction

    // The ALU sits outside the sequencer; model it combinationally from alu_*.
    always_comb alu_result = alu_model(alu_ctrl, alu_a, alu_b, alu_shamt);

    // Reference: is this request rejected, and how many cycles until the response.
    function automatic logic exp_error(input logic [7:0] op, input logic [31:0] b);
        return !(op >= 8'h02 && op <= 8'h0E) || (op == 8'h07 && b == 32'd0);
    endfunction

    function automatic int exp_latency(input logic [7:0] op, input logic [31:0] b);
        if (exp_error(op, b)) return 1;
        if (op == 8'h06) return 4;
        if (op == 8'h07) return 8;
        return 1;
    endfunction

    function automatic logic [63:0] exp_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        return exp_error(op, b) ? 64'd0 : alu_model(op, a, b, sh);
    endfunction

    // Drive one request, measure latency/busy cycles, capture the response, then handshake.
    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int lat, output int nbusy,
                         output logic [63:0] res, output logic err, output logic zero,
                         output logic busy_after);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nbusy = 0;
        while (!rsp_valid && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk); #1; lat++;
        end
        res = rsp_result; err = rsp_err; zero = rsp_zero;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset;
        clr_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 8'h55; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_shamt = 5'd9;
        repeat (3) @(posedge clk);
        #1;
        asserts++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: busy=%b req_ready=%b rsp_valid=%b want 0 1 0", busy, req_ready, rsp_valid); end
        asserts++; if ({alu_a, alu_b, alu_ctrl, alu_shamt} !== 77'd0) begin
            fails++; $display("FAIL reset_alu: a=%h b=%h ctrl=%h sh=%h want all 0", alu_a, alu_b, alu_ctrl, alu_shamt); end
        asserts++; if (rsp_result !== 64'd0 || rsp_err !== 1'b0 || rsp_zero !== 1'b1) begin
            fails++; $display("FAIL reset_rsp: result=%h err=%b zero=%b want 0 0 1", rsp_result, rsp_err, rsp_zero); end
        clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        int lat, nb; logic [63:0] res; logic err, zero, ba;
        do_op(8'h04, 32'd5, 32'd7, 5'd0, lat, nb, res, err, zero, ba);
        asserts++; if (lat !== 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
        asserts++; if (res !== 64'hC || err !== 1'b0 || zero !== 1'b0) begin
            fails++; $display("FAIL add_result: got %h err=%b zero=%b want c 0 0", res, err, zero); end
        asserts++; if (ba !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL add_idle: busy=%b req_ready=%b rsp_valid=%b want 0 1 0", ba, req_ready, rsp_valid); end
    endtask

    task automatic test_mul;
        int lat, nb; logic [63:0] res; logic err, zero, ba;
        do_op(8'h06, 32'hFFFF_FFFF, 32'd2, 5'd0, lat, nb, res, err, zero, ba);
        asserts++; if (lat !== 4) begin fails++; $display("FAIL mul_latency: got %0d want 4", lat); end
        asserts++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE || err !== 1'b0) begin
            fails++; $display("FAIL mul_result: got %h err=%b want fffffffffffffffe 0", res, err); end
    endtask

    task automatic test_div;
        int lat, nb; logic [63:0] res; logic err, zero, ba;
        do_op(8'h07, 32'd17, 32'd5, 5'd0, lat, nb, res, err, zero, ba);
        asserts++; if (lat !== 8) begin fails++; $display("FAIL div_latency: got %0d want 8", lat); end
        asserts++; if (res !== {32'd2, 32'd3} || err !== 1'b0) begin
            fails++; $display("FAIL div_result: got %h err=%b want 0000000200000003 0", res, err); end
        do_op(8'h07, 32'd9, 32'd0, 5'd0, lat, nb, res, err, zero, ba);
        asserts++; if (lat !== 1) begin fails++; $display("FAIL div0_latency: got %0d want 1", lat); end
        asserts++; if (res !== 64'd0 || err !== 1'b1 || zero !== 1'b1) begin
            fails++; $display("FAIL div0_result: got %h err=%b zero=%b want 0 1 1", res, err, zero); end
    endtask

    task automatic test_illegal;
        int lat, nb; logic [63:0] res; logic err, zero, ba;
        logic [7:0] ops [2];
        ops[0] = 8'h00; ops[1] = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 32'h1111_2222, 32'h3333_4444, 5'd3, lat, nb, res, err, zero, ba);
            asserts++; if (lat !== 1 || nb !== 1 || ba !== 1'b0) begin
                fails++; $display("FAIL illegal_timing op=%h: lat=%0d busy_cycles=%0d busy_after=%b want 1 1 0", ops[i], lat, nb, ba); end
            asserts++; if (res !== 64'd0 || err !== 1'b1 || zero !== 1'b1) begin
                fails++; $display("FAIL illegal_result op=%h: got %h err=%b zero=%b want 0 1 1", ops[i], res, err, zero); end
        end
    endtask

    task automatic test_backpressure;
        int w;
        logic [63:0] exp;
        exp = 64'd7;
        req_op = 8'h04; req_a = 32'd3; req_b = 32'd4; req_shamt = 5'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 40) begin @(posedge clk); #1; w++; end
        for (int c = 0; c < 3; c++) begin
            req_op = 8'h05; req_a = 32'd100 + c; req_b = 32'd1; req_valid = 1'b1;
            @(posedge clk); #1;
            asserts++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== exp || rsp_err !== 1'b0 || alu_ctrl !== 8'h04) begin
                fails++; $display("FAIL stall_hold c=%0d: valid=%b req_ready=%b result=%h err=%b ctrl=%h want 1 0 %h 0 04",
                                  c, rsp_valid, req_ready, rsp_result, rsp_err, alu_ctrl, exp); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        asserts++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== exp || alu_a !== 32'd3) begin
            fails++; $display("FAIL stall_release: valid=%b req_ready=%b result=%h alu_a=%h want 0 1 %h 3",
                              rsp_valid, req_ready, rsp_result, alu_a, exp); end
    endtask

    task automatic test_reset_mid_exec;
        int lat, nb, seen; logic [63:0] res; logic err, zero, ba;
        req_op = 8'h07; req_a = 32'd100; req_b = 32'd7; req_shamt = 5'd0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr_n = 1'b0;
        @(posedge clk); #1;
        clr_n = 1'b1;
        asserts++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL midreset_ctl: busy=%b rsp_valid=%b req_ready=%b want 0 0 1", busy, rsp_valid, req_ready); end
        asserts++; if ({alu_a, alu_b, alu_ctrl, alu_shamt} !== 77'd0 || rsp_result !== 64'd0 || rsp_zero !== 1'b1) begin
            fails++; $display("FAIL midreset_state: a=%h b=%h ctrl=%h result=%h zero=%b want 0 0 0 0 1",
                              alu_a, alu_b, alu_ctrl, rsp_result, rsp_zero); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        asserts++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_rsp: valid seen %0d cycles want 0", seen); end
        do_op(8'h04, 32'd40, 32'd2, 5'd0, lat, nb, res, err, zero, ba);
        asserts++; if (lat !== 1 || res !== 64'd42 || err !== 1'b0) begin
            fails++; $display("FAIL midreset_add: lat=%0d result=%h err=%b want 1 2a 0", lat, res, err); end
    endtask

    task automatic test_random;
        int lat, nb; logic [63:0] res; logic err, zero, ba;
        logic [7:0] op; logic [31:0] a, b; logic [4:0] sh;
        int sel;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 15);
            if (sel <= 12)      op = 8'(sel + 2);
            else if (sel == 13) op = 8'h00;
            else if (sel == 14) op = 8'hFF;
            else                op = 8'($urandom_range(15, 255));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 4) == 0) a = b;
            sh = 5'($urandom_range(0, 31));
            do_op(op, a, b, sh, lat, nb, res, err, zero, ba);
            asserts++; if (lat !== exp_latency(op, b) || nb !== lat) begin
                fails++; $display("FAIL rand_latency n=%0d op=%h b=%h: lat=%0d busy=%0d want %0d", n, op, b, lat, nb, exp_latency(op, b)); end
            asserts++; if (res !== exp_result(op, a, b, sh) || err !== exp_error(op, b) || zero !== (exp_result(op, a, b, sh) == 64'd0)) begin
                fails++; $display("FAIL rand_result n=%0d op=%h a=%h b=%h sh=%0d: got %h err=%b zero=%b want %h %b",
                                  n, op, a, b, sh, res, err, zero, exp_result(op, a, b, sh), exp_error(op, b)); end
            asserts++; if (alu_ctrl !== op || alu_a !== a || alu_b !== b || alu_shamt !== sh) begin
                fails++; $display("FAIL rand_operands n=%0d: ctrl=%h a=%h b=%h sh=%0d want %h %h %h %0d",
                                  n, alu_ctrl, alu_a, alu_b, alu_shamt, op, a, b, sh); end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_mul;
        test_div;
        test_illegal;
        test_backpressure;
        test_reset_mid_exec;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
